// File: rtl/axilite_cmd_master.sv
// axilite_cmd_master: turns single read/write commands into AXI-Lite transactions, one at a time.
// Ports: aclk/aresetn clock and async active-low reset; cmd_* command request (valid/ready);
// rsp_* response (valid/ready) carrying read data and BRESP/RRESP; timeout_err sticky
// response-wait flag; m_axi_* AXI-Lite master channels AW, W, B, AR, R.
module axilite_cmd_master #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                timeout_err,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [7:0] TMO = 8'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_t;
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                aw_q, aw_d, w_q, w_d, ar_q, ar_d;
  logic                rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic [7:0]          cnt_q, cnt_d, cnt_inc;
  logic                tout_q, tout_d;
  // Gated by aresetn so the command port is closed for the whole reset interval.
  assign cmd_ready     = (state_q == IDLE) && aresetn;
  assign rsp_valid     = state_q == RSP;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign timeout_err   = tout_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_awvalid = aw_q;
  assign m_axi_wvalid  = w_q;
  assign m_axi_arvalid = ar_q;
  assign m_axi_bready  = state_q == WR;
  assign m_axi_rready  = state_q == RD;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign cnt_inc       = (cnt_q == TMO) ? cnt_q : cnt_q + 8'd1;
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_d        = aw_q;
    w_d         = w_q;
    ar_d        = ar_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    cnt_d       = cnt_q;
    tout_d      = tout_q;
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready) begin
        state_d = cmd_write ? WR : RD;
        addr_d  = cmd_addr;
        wdata_d = cmd_wdata;
        wstrb_d = cmd_wstrb;
        aw_d    = cmd_write;
        w_d     = cmd_write;
        ar_d    = !cmd_write;
        cnt_d   = '0;
        tout_d  = 1'b0;
      end
      WR: begin
        // AW and W retire independently; B may land in the same cycle as either.
        aw_d   = aw_q && !m_axi_awready;
        w_d    = w_q && !m_axi_wready;
        cnt_d  = cnt_inc;
        tout_d = tout_q || (cnt_inc == TMO);
        if (m_axi_bvalid) begin
          state_d     = RSP;
          aw_d        = 1'b0;
          w_d         = 1'b0;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axi_bresp;
        end
      end
      RD: begin
        ar_d   = ar_q && !m_axi_arready;
        cnt_d  = cnt_inc;
        tout_d = tout_q || (cnt_inc == TMO);
        if (m_axi_rvalid) begin
          state_d     = RSP;
          ar_d        = 1'b0;
          rsp_write_d = 1'b0;
          rsp_rdata_d = m_axi_rdata;
          rsp_resp_d  = m_axi_rresp;
        end
      end
      RSP: state_d = rsp_ready ? IDLE : RSP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_q        <= 1'b0;
      w_q         <= 1'b0;
      ar_q        <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      cnt_q       <= '0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_q        <= aw_d;
      w_q         <= w_d;
      ar_q        <= ar_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      cnt_q       <= cnt_d;
      tout_q      <= tout_d;
    end
  end
endmodule

// File: tb/tb_axilite_cmd_master.sv
// tb_axilite_cmd_master: directed table-driven bench for axilite_cmd_master with a scripted AXI-Lite slave.
module tb_axilite_cmd_master;
  logic        aclk, aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [8:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        timeout_err;
  logic [8:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  axilite_cmd_master #(.ADDR_W(9), .DATA_W(32), .TIMEOUT(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout_err(timeout_err),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly, hold;
    logic [31:0] rdata;
    logic [1:0]  resp;
    bit          noise;
    int          exp_rsp_c;
    logic [31:0] exp_rdata;
    int          exp_tout_c;
  } vec_t;

  vec_t vecs[8];
  int   nvec = 0, nerr = 0;
  logic last_tout = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_slave();
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rsp_ready = 0;
  endtask

  task automatic run(input vec_t v);
    int c, aw_c, w_c, b_c, ar_c, r_c, rsp_c, tout_c, last_c, guard;
    int n_aw, n_w, n_b, n_ar, n_r;
    bit done;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(posedge aclk); #1; guard++; end
    chk("idle_ready", cmd_ready, 1);
    chk("tout_before_accept", timeout_err, last_tout);
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    bresp = v.resp; rresp = v.resp; rdata = v.rdata;
    @(posedge aclk); #1;
    if (v.noise) begin
      cmd_write = ~v.wr; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata; cmd_wstrb = ~v.wstrb;
    end else cmd_valid = 0;
    c = 1; aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0; rsp_c = 0; tout_c = 0;
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; done = 0;
    chk("c1_valids", {awvalid, wvalid, arvalid, cmd_ready}, {v.wr, v.wr, !v.wr, 1'b0});
    while (!done && c < 100) begin
      if (awvalid) chk("aw_payload", awaddr, v.addr);
      if (wvalid) chk("w_payload", {wdata, wstrb}, {v.wdata, v.wstrb});
      if (arvalid) chk("ar_payload", araddr, v.addr);
      if (timeout_err && tout_c == 0) tout_c = c;
      if (rsp_valid) begin
        if (rsp_c == 0) begin rsp_c = c; cmd_valid = 0; end
        chk("rsp_payload", {rsp_write, rsp_rdata, rsp_resp}, {v.wr, v.exp_rdata, v.resp});
      end
      last_c = (aw_c > w_c) ? aw_c : w_c;
      awready   = c >= 1 + v.aw_dly;
      wready    = c >= 1 + v.w_dly;
      arready   = c >= 1 + v.ar_dly;
      bvalid    = aw_c != 0 && w_c != 0 && b_c == 0 && c > last_c + v.b_dly;
      rvalid    = ar_c != 0 && r_c == 0 && c > ar_c + v.r_dly;
      rsp_ready = rsp_c != 0 && c >= rsp_c + v.hold;
      if (awvalid && awready) begin n_aw++; aw_c = c; end
      if (wvalid && wready) begin n_w++; w_c = c; end
      if (bvalid && bready) begin n_b++; b_c = c; end
      if (arvalid && arready) begin n_ar++; ar_c = c; end
      if (rvalid && rready) begin n_r++; r_c = c; end
      if (rsp_valid && rsp_ready) done = 1;
      @(posedge aclk); #1;
      c++;
    end
    idle_slave();
    cmd_valid = 0;
    chk("rsp_done", done, 1);
    chk("rsp_cycle", rsp_c, v.exp_rsp_c);
    chk("tout_cycle", tout_c, v.exp_tout_c);
    chk("hs_counts", {4'(n_aw), 4'(n_w), 4'(n_b), 4'(n_ar), 4'(n_r)}, v.wr ? 20'h11100 : 20'h00011);
    chk("ready_after_rsp", {cmd_ready, rsp_valid}, 2'b10);
    last_tout = v.exp_tout_c != 0;
  endtask

  initial begin
    //          wr  addr    wdata         strb aw w  b  ar r  hold rdata         resp  noise rsp rdata_exp     tout
    vecs[0] = '{1'b1, 9'h004, 32'h0000000A, 4'hF, 0, 0, 0, 0, 0, 0, 32'h11111111, 2'b00, 0, 3,  32'h0,         0};
    vecs[1] = '{1'b0, 9'h000, 32'h0,        4'h0, 0, 0, 0, 4, 0, 0, 32'h00000005, 2'b00, 0, 7,  32'h00000005,  0};
    vecs[2] = '{1'b1, 9'h010, 32'hDEADBEEF, 4'h5, 0, 3, 0, 0, 0, 1, 32'h22222222, 2'b00, 0, 6,  32'h0,         0};
    vecs[3] = '{1'b1, 9'h1FC, 32'h12345678, 4'h8, 0, 0, 0, 0, 0, 5, 32'h0,        2'b10, 0, 3,  32'h0,         0};
    vecs[4] = '{1'b1, 9'h020, 32'hA5A5A5A5, 4'hC, 0, 0, 20, 0, 0, 0, 32'h0,       2'b00, 0, 23, 32'h0,         9};
    vecs[5] = '{1'b0, 9'h0A8, 32'h0,        4'h0, 0, 0, 0, 0, 0, 0, 32'hCAFEF00D, 2'b11, 1, 3,  32'hCAFEF00D,  0};
    vecs[6] = '{1'b1, 9'h100, 32'h00000000, 4'h0, 2, 0, 0, 0, 0, 0, 32'h33333333, 2'b01, 0, 5,  32'h0,         0};
    vecs[7] = '{1'b0, 9'h0FF, 32'h0,        4'h0, 0, 0, 0, 0, 3, 2, 32'h80000001, 2'b10, 0, 6,  32'h80000001,  0};
    aresetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    bresp = '0; rresp = '0; rdata = '0;
    idle_slave();
    #12;
    chk("reset_ctrl", {cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid, timeout_err}, 8'h00);
    chk("reset_rsp", {rsp_write, rsp_rdata, rsp_resp, awprot, arprot}, '0);
    @(negedge aclk) aresetn = 1;
    @(posedge aclk); #1;
    chk("ready_after_release", cmd_ready, 1);
    for (int i = 0; i < 8; i++) run(vecs[i]);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 9'h040; cmd_wdata = 32'h0BADF00D; cmd_wstrb = 4'hF;
    @(posedge aclk); #1;
    cmd_valid = 0;
    @(posedge aclk); #1;
    chk("pre_reset_wr", {awvalid, wvalid, cmd_ready}, 3'b110);
    #3 aresetn = 0;
    #1;
    chk("midreset_ctrl", {awvalid, wvalid, arvalid, bready, rsp_valid, cmd_ready, timeout_err}, 7'h00);
    chk("midreset_rsp", {rsp_write, rsp_rdata, rsp_resp}, '0);
    @(negedge aclk) aresetn = 1;
    @(posedge aclk); #1;
    chk("post_reset", {cmd_ready, awvalid, wvalid, rsp_valid}, 4'b1000);
    repeat (3) @(posedge aclk);
    #1 chk("no_orphan_rsp", {rsp_valid, cmd_ready}, 2'b01);
    last_tout = 1'b0;
    run(vecs[0]);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/axilite_cmd_master.md
AXILITE_CMD_MASTER -- requirements
Module: axilite_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, AXI-Lite address width.
REQ-002 SHALL have parameter DATA_W, default 32, AXI-Lite data width; strobe width = DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT, default 255, the response-wait cycle limit before the error flag is raised.
REQ-004 SHALL use one clock, aclk; reset is asynchronous and active-low, aresetn.
REQ-005 SHALL have ports as listed (name  direction  width  meaning):
- aclk  in  1  clock
- aresetn  in  1  async active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  DATA_W/8  write strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_write  out  1  response is for a write
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_resp  out  2  captured BRESP/RRESP
- timeout_err  out  1  sticky timeout flag
- AXI-Lite master channels, all with the m_axi_ prefix:
  - awaddr/awvalid out, awready in
  - wdata/wstrb/wvalid out, wready in
  - bresp/bvalid in, bready out
  - araddr/arvalid out, arready in
  - rdata/rresp/rvalid in, rready out
  - awprot/arprot out, 3 bits, tied to 3'b000

Function
REQ-006 SHALL implement the states IDLE, WR, RD and RSP, with at most one transaction outstanding.
REQ-007 SHALL assert cmd_ready only in IDLE; a command is accepted on cmd_valid&&cmd_ready, and addr, wdata and wstrb are registered on that edge.
REQ-008 On an accepted write, the block SHALL go IDLE->WR and assert awvalid and wvalid in the next cycle; awaddr, wdata and wstrb come from the registered values.
REQ-009 In WR, awvalid SHALL deassert after its own handshake and wvalid after its own, independently; simultaneous or either-order handshakes SHALL both be legal.
REQ-010 SHALL hold awvalid/wvalid and their payloads stable until the matching ready; a valid is never withdrawn.
REQ-011 In WR, bready SHALL be 1; on bvalid&&bready the block captures bresp, sets rsp_write=1 and rsp_rdata=0, and goes WR->RSP.
REQ-012 A B handshake SHALL be accepted even if the AW or W handshake completes in the same cycle.
REQ-013 On an accepted read, the block SHALL go IDLE->RD and assert arvalid in the next cycle, holding it until arready.
REQ-014 In RD, rready SHALL be 1; on rvalid&&rready the block captures rdata and rresp, sets rsp_write=0, and goes RD->RSP.
REQ-015 In RSP, rsp_valid SHALL be 1 with stable payload until rsp_ready; the handshake returns the block to IDLE.
REQ-016 cmd_ready SHALL become 1 the cycle after the rsp handshake; there is no same-cycle bypass.
REQ-017 Minimum latency with a zero-wait slave: accept at cycle 0, AW/W or AR at cycle 1, B/R at cycle 2, rsp_valid at cycle 3.
REQ-018 An 8-bit counter SHALL clear on command accept and increment each cycle in WR or RD, saturating at TIMEOUT.
REQ-019 When the counter reaches TIMEOUT, timeout_err SHALL set; the transaction keeps waiting and is never aborted.
REQ-020 timeout_err SHALL clear only on the next command accept or on reset.
REQ-021 cmd_* inputs SHALL be ignored outside IDLE.

Reset
REQ-022 On aresetn low, outputs SHALL immediately take these values:
- state IDLE
- cmd_ready 0 while in reset, 1 from the first cycle after release
- awvalid, wvalid, arvalid, bready, rready, rsp_valid all 0
- rsp_rdata, rsp_resp, rsp_write 0
- timeout_err 0
- counter 0
REQ-023 Reset asserted mid-transaction SHALL abandon the transaction with no response; after release, the block is in IDLE with cmd_ready=1.

Verification
REQ-024 Write addr 0x004, wdata 0x0000000A, wstrb 0xF, zero-wait slave with BRESP 00 -> awaddr 0x004 and wdata 0x0A at cycle 1; rsp_valid at cycle 3 with rsp_write=1, rsp_resp=00, rsp_rdata=0.
REQ-025 Read addr 0x000, slave returns RDATA 0x5, RRESP 00 after 4 wait cycles -> arvalid held until arready; rsp_rdata=0x00000005, rsp_write=0.
REQ-026 Write where wready arrives 3 cycles after awready -> awvalid drops after AW only, wvalid stays high until its own handshake, then single B and single response.
REQ-027 Slave returns BRESP=10, rsp_ready held low 5 cycles -> rsp_valid and rsp_resp=10 stable for 5 cycles; cmd_ready=1 the cycle after rsp_ready.
REQ-028 TIMEOUT=8, bvalid delayed 20 cycles -> timeout_err=1 from wait cycle 8; the response still completes; the next command accept clears timeout_err.
REQ-029 aresetn pulsed low while in WR with awvalid=1 -> awvalid, wvalid and rsp_valid go 0 immediately; cmd_ready=1 after release.
